// File: rtl/step_driver_if.sv
// rtl/step_driver_if.sv - burst request handshake between upstream logic and step_driver
interface step_driver_if #(
    parameter int CW = 4
);
    logic          req_valid;
    logic [CW-1:0] req_cnt;
    logic          req_ready;

    modport master (
        output req_valid,
        output req_cnt,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_cnt,
        output req_ready
    );
endinterface

// File: rtl/step_driver.sv
// rtl/step_driver.sv - step strobe burst generator with receiver position mirror (optional STEP_CHECK_EN)
module step_driver #(
    parameter int MOD = 5,
    parameter int GAP = 1,
    parameter int CW  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    step_driver_if.slave       req,
    output logic               x,
    output logic               busy,
    output logic               done,
    output logic [2:0]         pos,
    output logic               wrap,
    input  logic               y_in,
    output logic               err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAPW  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [2:0] POS_MAX = 3'(MOD - 1);
    localparam logic [3:0] GAP_V   = 4'(GAP);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] rem;
    logic [CW-1:0] rem_nxt;
    logic [3:0]    gcnt;
    logic [3:0]    gcnt_nxt;
    logic          accept;

    // All handshake and strobe outputs decode straight from the state register.
    assign req.req_ready = (state == IDLE);
    assign busy          = (state != IDLE);
    assign x             = (state == PULSE);
    assign done          = (state == DONE);
    assign accept        = req.req_valid & req.req_ready;

    // State, remaining-step and gap counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rem   <= '0;
            gcnt  <= '0;
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
            gcnt  <= gcnt_nxt;
        end
    end

    // Next-state logic: a zero-length burst goes straight to DONE.
    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        gcnt_nxt  = gcnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req.req_cnt == '0) begin
                        state_nxt = DONE;
                    end else begin
                        rem_nxt   = req.req_cnt;
                        state_nxt = PULSE;
                    end
                end
            end
            PULSE: begin
                rem_nxt = rem - 1'b1;
                if (rem == CW'(1)) begin
                    state_nxt = DONE;
                end else if (GAP_V == 4'd0) begin
                    state_nxt = PULSE;
                end else begin
                    gcnt_nxt  = GAP_V;
                    state_nxt = GAPW;
                end
            end
            GAPW: begin
                if (gcnt <= 4'd1) begin
                    state_nxt = PULSE;
                end else begin
                    gcnt_nxt = gcnt - 4'd1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Mirror the receiver: advance on the same edge that closes an x pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos  <= '0;
            wrap <= 1'b0;
        end else if (state == PULSE) begin
            pos  <= (pos == POS_MAX) ? 3'd0 : pos + 3'd1;
            wrap <= (pos == POS_MAX);
        end else begin
            wrap <= 1'b0;
        end
    end

`ifdef STEP_CHECK_EN
    // Sticky flag: receiver y must equal (pos == MOD-1) every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (y_in != (pos == POS_MAX)) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_y_in;
    assign unused_y_in = y_in;
    assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_step_driver.sv
// tb/tb_step_driver.sv - directed self-checking bench for step_driver
module tb_step_driver;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    step_driver_if #(.CW(4)) rq ();
    step_driver_if #(.CW(4)) rq0 ();

    logic       x, busy, done, wrap, err, y_in;
    logic [2:0] pos;
    logic       x0, busy0, done0, wrap0, err0;
    logic [2:0] pos0;

    logic       y_force_en = 1'b0;
    logic       y_force_val = 1'b0;
    logic [2:0] rx;

    step_driver #(.MOD(5), .GAP(1), .CW(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(rq),
        .x(x), .busy(busy), .done(done), .pos(pos), .wrap(wrap),
        .y_in(y_in), .err(err)
    );

    step_driver #(.MOD(5), .GAP(0), .CW(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(rq0),
        .x(x0), .busy(busy0), .done(done0), .pos(pos0), .wrap(wrap0),
        .y_in(1'b0), .err(err0)
    );

    // Independent modulo-5 receiver driven by dut.x.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rx <= 3'd0;
        else if (x)  rx <= (rx == 3'd4) ? 3'd0 : rx + 3'd1;
    end
    assign y_in = y_force_en ? y_force_val : (rx == 3'd4);

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rq.req_valid = 1'b0;
        rq0.req_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic burst(input logic [3:0] n);
        int guard;
        rq.req_cnt = n;
        rq.req_valid = 1'b1;
        tick();
        rq.req_valid = 1'b0;
        guard = 0;
        while (!done && guard < 60) begin
            tick();
            guard++;
        end
        check("burst_done", done, 1);
        tick();
    endtask

    // Test 1 expectations, cycles e0..e6.
    logic t1_x   [7] = '{1, 0, 1, 0, 1, 0, 0};
    logic [2:0] t1_pos [7] = '{0, 1, 1, 2, 2, 3, 3};
    logic t1_done[7] = '{0, 0, 0, 0, 0, 1, 0};
    logic t1_rdy [7] = '{0, 0, 0, 0, 0, 0, 1};
    // Test 4 expectations (GAP=0, valid held), cycles e0..e10.
    logic t4_x   [11] = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 0};
    logic t4_done[11] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
    logic t4_rdy [11] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};

    initial begin
        int xcnt, wcnt, guard;
        rq.req_valid = 1'b0;
        rq.req_cnt   = '0;
        rq0.req_valid = 1'b0;
        rq0.req_cnt   = '0;

        // Reset state
        tick();
        check("rst_x", x, 0);
        check("rst_pos", pos, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wrap", wrap, 0);
        check("rst_err", err, 0);
        check("rst_ready", rq.req_ready, 1);
        rst_n = 1'b1;
        tick();

        // Test 1: 3-step burst
        rq.req_cnt = 4'd3;
        rq.req_valid = 1'b1;
        tick();
        rq.req_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            check($sformatf("t1_x_e%0d", i), x, t1_x[i]);
            check($sformatf("t1_pos_e%0d", i), pos, t1_pos[i]);
            check($sformatf("t1_done_e%0d", i), done, t1_done[i]);
            check($sformatf("t1_rdy_e%0d", i), rq.req_ready, t1_rdy[i]);
            tick();
        end

        // Test 3: zero-length burst, pos stays 3
        rq.req_cnt = 4'd0;
        rq.req_valid = 1'b1;
        tick();
        rq.req_valid = 1'b0;
        check("t3_done_e0", done, 1);
        check("t3_x_e0", x, 0);
        tick();
        check("t3_done_e1", done, 0);
        check("t3_rdy_e1", rq.req_ready, 1);
        check("t3_pos", pos, 3);

        // Test 2: 7 steps from pos 0, single wrap, final pos 2
        do_reset();
        rq.req_cnt = 4'd7;
        rq.req_valid = 1'b1;
        tick();
        rq.req_valid = 1'b0;
        xcnt = 0;
        wcnt = 0;
        guard = 0;
        while (!done && guard < 40) begin
            if (x) xcnt++;
            if (wrap) begin
                wcnt++;
                check("t2_wrap_pos", pos, 0);
            end
            tick();
            guard++;
        end
        check("t2_done_seen", done, 1);
        check("t2_xcnt", xcnt, 7);
        check("t2_wcnt", wcnt, 1);
        check("t2_pos", pos, 2);

        // Test 4: GAP=0, valid held high for two bursts of 4
        do_reset();
        rq0.req_cnt = 4'd4;
        rq0.req_valid = 1'b1;
        tick();
        for (int i = 0; i < 11; i++) begin
            check($sformatf("t4_x_e%0d", i), x0, t4_x[i]);
            check($sformatf("t4_done_e%0d", i), done0, t4_done[i]);
            check($sformatf("t4_rdy_e%0d", i), rq0.req_ready, t4_rdy[i]);
            tick();
        end
        rq0.req_valid = 1'b0;
        check("t4_pos", pos0, 3);

        // Test 5: reset during the 2nd gap of a 5-step burst
        do_reset();
        rq.req_cnt = 4'd5;
        rq.req_valid = 1'b1;
        tick();
        rq.req_valid = 1'b0;
        tick();
        tick();
        tick();
        check("t5_pre_busy", busy, 1);
        check("t5_pre_pos", pos, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_x", x, 0);
        check("t5_pos", pos, 0);
        check("t5_busy", busy, 0);
        check("t5_ready", rq.req_ready, 1);
        check("t5_done", done, 0);
        tick();
        rst_n = 1'b1;
        xcnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (done || x) xcnt++;
            tick();
        end
        check("t5_no_activity", xcnt, 0);

        // Test 6: 20 bursts against the receiver model, then forced y mismatch
        do_reset();
        for (int i = 0; i < 20; i++) begin
            burst(4'((i % 7) + 1));
        end
        check("t6_pos_77", pos, 2);
        check("t6_mirror", pos, rx);
        check("t6_err_clean", err, 0);
        burst(4'd2);
        check("t6_pos4", pos, 4);
        y_force_en = 1'b1;
        y_force_val = 1'b0;
        tick();
        y_force_en = 1'b0;
`ifdef STEP_CHECK_EN
        check("t6_err_set", err, 1);
        tick();
        tick();
        check("t6_err_sticky", err, 1);
`else
        check("t6_err_tied", err, 0);
`endif
        do_reset();
        check("t6_err_reset", err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
